// File: rtl/universal_shift_reg.sv
// Universal shift register: shift/rotate/arithmetic-shift/load under sel,
// plus a start-triggered WIDTH-bit serial-out burst with busy/done status.
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             sin,
  input  logic [2:0]       sel,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  output logic [WIDTH-1:0] par_out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             sout_q, sout_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    sout_d  = sout_q;

    if (ld) begin
      // A load aborts any burst silently: straight to IDLE, no done pulse.
      par_d   = par_in;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          par_d  = {sin, par_q[WIDTH-1:1]};
          sout_d = par_q[0];
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        IDLE: begin
          if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end else if (en) begin
            unique case (sel)
              3'b000: begin
                par_d  = {sin, par_q[WIDTH-1:1]};
                sout_d = par_q[0];
              end
              3'b001: begin
                par_d  = {par_q[WIDTH-2:0], sin};
                sout_d = par_q[WIDTH-1];
              end
              3'b010: par_d = par_in;
              3'b100: begin
                par_d  = {par_q[0], par_q[WIDTH-1:1]};
                sout_d = par_q[0];
              end
              3'b101: begin
                par_d  = {par_q[WIDTH-2:0], par_q[WIDTH-1]};
                sout_d = par_q[WIDTH-1];
              end
              3'b110: begin
                par_d  = {par_q[WIDTH-1], par_q[WIDTH-1:1]};
                sout_d = par_q[0];
              end
              default: ;
            endcase
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
    end
  end

  assign par_out = par_q;
  assign sout    = sout_q;
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Randomized + directed bench for universal_shift_reg; a behavioural model
// pushes per-edge expectations into a queue that a negedge monitor drains.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         clock;
  logic         clear_n;
  logic         sin;
  logic [2:0]   sel;
  logic         en;
  logic         ld;
  logic [W-1:0] par_in;
  logic         start;
  logic [W-1:0] par_out;
  logic         sout;
  logic         busy;
  logic         done;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .sin     (sin),
    .sel     (sel),
    .en      (en),
    .ld      (ld),
    .par_in  (par_in),
    .start   (start),
    .par_out (par_out),
    .sout    (sout),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] par;
    logic         so;
    logic         bz;
    logic         dn;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: register value, serial bit, shifts remaining in a burst, done flag.
  logic [W-1:0] m_val;
  logic         m_sout;
  int           m_left;
  logic         m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_val  = '0;
    m_sout = 1'b0;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic st, input logic e,
                            input logic [2:0] s, input logic si, input logic [W-1:0] pi);
    logic [W-1:0] msb;
    msb = W'(1) << (W - 1);
    if (l) begin
      m_val  = pi;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_sout = m_val[0];
      m_val  = (m_val >> 1) | (si ? msb : '0);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (st) begin
      m_left = W;
    end else if (e) begin
      case (s)
        3'd0: begin m_sout = m_val[0];   m_val = (m_val >> 1) | (si ? msb : '0); end
        3'd1: begin m_sout = m_val[W-1]; m_val = (m_val << 1) | W'(si); end
        3'd2: m_val = pi;
        3'd4: begin m_sout = m_val[0];   m_val = (m_val >> 1) | (m_val << (W - 1)); end
        3'd5: begin m_sout = m_val[W-1]; m_val = (m_val << 1) | (m_val >> (W - 1)); end
        3'd6: begin m_sout = m_val[0];   m_val = (m_val >> 1) | (m_val & msb); end
        default: ;
      endcase
    end
  endtask

  // One clock edge of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic step(input logic l, input logic st, input logic e,
                      input logic [2:0] s, input logic si, input logic [W-1:0] pi);
    exp_t x;
    @(negedge clock);
    #1;
    ld = l; start = st; en = e; sel = s; sin = si; par_in = pi;
    model_edge(l, st, e, s, si, pi);
    x.par = m_val;
    x.so  = m_sout;
    x.bz  = (m_left > 0);
    x.dn  = m_done;
    exp_q.push_back(x);
  endtask

  task automatic idle_inputs();
    ld = 1'b0; start = 1'b0; en = 1'b0; sel = 3'd0; sin = 1'b0; par_in = '0;
  endtask

  // Scoreboard monitor: compares one queued expectation per falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("par_out", 32'(par_out), 32'(x.par));
        check("sout",    32'(sout),    32'(x.so));
        check("busy",    32'(busy),    32'(x.bz));
        check("done",    32'(done),    32'(x.dn));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    clear_n = 1'b0;
    model_reset();
    #3;
    check("reset_par_out", 32'(par_out), 32'h0);
    check("reset_flags", {29'd0, sout, busy, done}, 32'h0);
    @(negedge clock);
    clear_n = 1'b1;

    // Rotate right after load.
    step(1, 0, 0, 3'd0, 0, 8'hA5);
    step(0, 0, 1, 3'd4, 0, 8'h00);
    @(posedge clock); #1;
    check("rotr_par_out", 32'(par_out), 32'hD2);
    check("rotr_sout", 32'(sout), 32'h1);

    // Arithmetic shift right twice.
    step(1, 0, 0, 3'd0, 0, 8'h81);
    step(0, 0, 1, 3'd6, 1, 8'h00);
    step(0, 0, 1, 3'd6, 1, 8'h00);
    @(posedge clock); #1;
    check("asr_par_out", 32'(par_out), 32'hE0);
    check("asr_sout", 32'(sout), 32'h0);

    // Full burst: B4 shifted out LSB first, then DONE, then IDLE.
    step(1, 0, 0, 3'd0, 0, 8'hB4);
    step(0, 1, 0, 3'd0, 0, 8'h00);
    for (int i = 0; i < W; i++) step(0, 0, 1, 3'd1, 0, 8'h00);
    step(0, 1, 0, 3'd0, 0, 8'h00);
    @(posedge clock); #1;
    check("burst_par_out", 32'(par_out), 32'h00);
    check("burst_done_dropped_start", {30'd0, busy, done}, 32'h0);

    // Burst aborted by load after 3 shifts.
    step(1, 0, 0, 3'd0, 0, 8'hB4);
    step(0, 1, 0, 3'd0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd0, 0, 8'h00);
    step(1, 0, 0, 3'd0, 0, 8'h3C);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd0, 0, 8'h00);

    // Asynchronous clear mid-burst, then a fresh full burst.
    step(1, 0, 0, 3'd0, 0, 8'hFF);
    step(0, 1, 0, 3'd0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd0, 1, 8'h00);
    @(negedge clock);
    idle_inputs();
    #2;
    clear_n = 1'b0;
    #1;
    check("async_clr_par_out", 32'(par_out), 32'h0);
    check("async_clr_flags", {29'd0, sout, busy, done}, 32'h0);
    model_reset();
    @(posedge clock); #2;
    check("clr_held_flags", {29'd0, sout, busy, done}, 32'h0);
    @(negedge clock); #2;
    clear_n = 1'b1;
    step(0, 1, 0, 3'd0, 1, 8'h00);
    for (int i = 0; i < W + 2; i++) step(0, 0, 0, 3'd0, 0, 8'h00);

    // en=0 holds; ld+start together loads only.
    step(1, 0, 0, 3'd0, 0, 8'h6B);
    step(0, 0, 1, 3'd1, 1, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 1, 8'h00);
    step(1, 1, 1, 3'd0, 0, 8'h5A);
    step(0, 0, 0, 3'd0, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), W'($urandom));
    end

    @(negedge clock);
    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 clear_n  input  1  asynchronous, active-low reset.
REQ-004 sin  input  1  serial fill bit for shifts.
REQ-005 sel  input  3  operation select (see REQ-012).
REQ-006 en  input  1  enables sel operations when the block is idle.
REQ-007 ld  input  1  synchronous parallel load; overrides all operations except reset.
REQ-008 par_in  input  WIDTH  parallel load data.
REQ-009 start  input  1  begins a WIDTH-bit serial-out burst.
REQ-010 par_out  output  WIDTH  register contents, registered.
REQ-011 sout  output  1  registered serial output; busy, done: output 1 each, burst status.

Function
REQ-012 sel decode when en=1, idle, ld=0, start=0:
- 000: shift right, {sin, par_out[WIDTH-1:1]}
- 001: shift left, {par_out[WIDTH-2:0], sin}
- 010: par_out <= par_in
- 011, 111: hold
- 100: rotate right
- 101: rotate left
- 110: arithmetic shift right, MSB replicated
REQ-013 sout updates only on edges that shift or rotate: right-type (000,100,110) -> old par_out[0]; left-type (001,101) -> old par_out[WIDTH-1]; all other edges hold sout.
REQ-014 en=0 with no ld, start or burst: par_out and sout hold.
REQ-015 Priority, highest first: clear_n, ld, active burst, start, en/sel.
REQ-016 FSM states: IDLE, SHIFT, DONE; 0..WIDTH-1 counter cnt.
REQ-017 IDLE, start=1, ld=0: next state SHIFT, cnt<=0, par_out unchanged on that edge.
REQ-018 SHIFT, each edge: right shift with sin fill, sout <= old par_out[0], cnt<=cnt+1; sel and en ignored.
REQ-019 SHIFT with cnt==WIDTH-1: that edge performs the final shift and moves to DONE; exactly WIDTH shifts per burst.
REQ-020 DONE lasts exactly one cycle, then IDLE; par_out and sout hold in DONE.
REQ-021 busy=1 exactly while in SHIFT; done=1 exactly while in DONE; both are registered outputs.
REQ-022 start is ignored in SHIFT and DONE; no queueing.
REQ-023 start=1 in DONE is dropped; a new burst needs start while in IDLE.
REQ-024 ld=1 in any state: par_out <= par_in, state <= IDLE, cnt <= 0, sout holds; done is not asserted for an aborted burst.
REQ-025 ld and start together in IDLE: load only; start is dropped.

Reset
REQ-026 clear_n=0 asynchronously forces par_out=0, sout=0, busy=0, done=0, state IDLE, cnt=0, independent of clock.
REQ-027 Reset asserted mid-burst aborts the burst with no done pulse.
REQ-028 After clear_n deasserts, the first active edge obeys REQ-015.

Verification (WIDTH=8)
REQ-029 ld=1, par_in=8'hA5, then en=1, sel=100 for 1 edge -> par_out=8'hD2, sout=1.
REQ-030 par_out=8'h81, sel=110, en=1, 2 edges -> par_out=8'hE0, sout=0.
REQ-031 par_out=8'hB4, sin=0, start pulse -> busy high 8 cycles; sout sequence 0,0,1,0,1,1,0,1; done high 1 cycle; par_out=8'h00.
REQ-032 During the burst in REQ-031, ld=1, par_in=8'h3C after 3 shifts -> par_out=8'h3C, busy=0 next cycle, done never asserted.
REQ-033 clear_n low between clock edges mid-burst -> all outputs 0 immediately; start after release runs a full 8-shift burst.
REQ-034 en=0 with sel=000 for 4 edges -> par_out and sout unchanged; ld=1 together with start=1 in IDLE -> par_in loaded, busy stays 0.
